// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine controller: keypad codes,
// coin values, FSM state encoding and a keypad-code classifier.
package vend_pkg;

    localparam logic [2:0] KP_NONE   = 3'b000;
    localparam logic [2:0] KP_C100   = 3'b001;
    localparam logic [2:0] KP_C500   = 3'b010;
    localparam logic [2:0] KP_CANDY  = 3'b101;
    localparam logic [2:0] KP_CHANGE = 3'b110;
    localparam logic [2:0] KP_CANCEL = 3'b111;

    localparam int COIN100_VAL = 100;
    localparam int COIN500_VAL = 500;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    // True for codes that may produce a key event (not none, not unused).
    function automatic logic is_valid_code(input logic [2:0] code);
        logic ok;
        case (code)
            KP_C100, KP_C500, KP_CANDY, KP_CHANGE, KP_CANCEL: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vend_ctrl_kp_event_det.sv
// Keypad edge detector: one event per key press, only when the key code
// rises from "none" to a valid code. Held keys and direct code-to-code
// transitions produce nothing.
module kp_event_det
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] kp_code,
    output logic       evt,
    output logic [2:0] evt_code
);

    logic [2:0] kp_prev;

    // Track the previous key code every cycle, regardless of FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kp_prev <= KP_NONE;
        end else begin
            kp_prev <= kp_code;
        end
    end

    // Event fires in the same cycle the new code is sampled, so its effect
    // lands on that edge in the controller.
    always_comb begin
        evt      = 1'b0;
        evt_code = KP_NONE;
        if ((kp_prev == KP_NONE) && is_valid_code(kp_code)) begin
            evt      = 1'b1;
            evt_code = kp_code;
        end else begin
            evt      = 1'b0;
            evt_code = KP_NONE;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit accumulation, candy dispense
// and change payout as a train of 100-unit pulses. All outputs registered.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CANDY_PRICE     = 300,
    parameter int MAX_CREDIT      = 1000,
    parameter int CREDIT_W        = 11,
    parameter int DISPENSE_CYCLES = 4,
    parameter int CHANGE_GAP      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          kp_code,
    output logic [CREDIT_W-1:0] credit,
    output logic                candy_out,
    output logic                change_100,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy
);

    localparam int CNT_MAX = (DISPENSE_CYCLES > CHANGE_GAP) ? DISPENSE_CYCLES : CHANGE_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    DISP_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GAP_LOAD  = CNT_W'(CHANGE_GAP - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
    localparam logic [CREDIT_W:0]   MAX_EXT   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE     = CREDIT_W'(CANDY_PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_100  = CREDIT_W'(COIN100_VAL);
    localparam logic [CREDIT_W-1:0] UNIT_500  = CREDIT_W'(COIN500_VAL);
    localparam logic [CREDIT_W-1:0] CR_ZERO   = CREDIT_W'(0);

    logic                evt;
    logic [2:0]          evt_code;
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_coin;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;

    kp_event_det u_kp_event_det (
        .clk      (clk),
        .reset    (reset),
        .kp_code  (kp_code),
        .evt      (evt),
        .evt_code (evt_code)
    );

    // Decode coin events and check the ceiling with one extra bit so the
    // sum can never wrap back under MAX_CREDIT.
    always_comb begin
        is_coin  = 1'b0;
        coin_val = CR_ZERO;
        case (evt_code)
            KP_C100: begin
                is_coin  = evt;
                coin_val = UNIT_100;
            end
            KP_C500: begin
                is_coin  = evt;
                coin_val = UNIT_500;
            end
            default: begin
                is_coin  = 1'b0;
                coin_val = CR_ZERO;
            end
        endcase
        coin_sum = {1'b0, credit} + {1'b0, coin_val};
        coin_ok  = (coin_sum <= MAX_EXT);
    end

    // Transaction FSM with credit, shared dwell counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            credit      <= CR_ZERO;
            cnt         <= CNT_ZERO;
            candy_out   <= 1'b0;
            change_100  <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            change_100  <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    candy_out <= 1'b0;
                    busy      <= 1'b0;
                    if (is_coin) begin
                        if (coin_ok) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (evt && (evt_code == KP_CANDY)) begin
                        if (credit >= PRICE) begin
                            credit    <= credit - PRICE;
                            cnt       <= DISP_LOAD;
                            candy_out <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_DISPENSE;
                        end else begin
                            deny <= 1'b1;
                        end
                    end else if (evt && ((evt_code == KP_CHANGE) || (evt_code == KP_CANCEL))) begin
                        if (credit != CR_ZERO) begin
                            cnt   <= CNT_ZERO;
                            busy  <= 1'b1;
                            state <= ST_CHANGE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DISPENSE: begin
                    coin_reject <= is_coin;
                    if (cnt == CNT_ZERO) begin
                        candy_out <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        candy_out <= 1'b1;
                        cnt       <= cnt - CNT_ONE;
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= is_coin;
                    if (cnt == CNT_ZERO) begin
                        change_100 <= 1'b1;
                        credit     <= credit - UNIT_100;
                        cnt        <= GAP_LOAD;
                        if (credit == UNIT_100) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            busy  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    candy_out <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus pushes the expected output
// changes (cycle stamp + full output tuple); a negedge monitor pops one
// entry every time the DUT output tuple changes.
module tb_vend_ctrl;

    localparam logic [2:0] KP_NONE   = 3'b000;
    localparam logic [2:0] KP_C100   = 3'b001;
    localparam logic [2:0] KP_C500   = 3'b010;
    localparam logic [2:0] KP_CANDY  = 3'b101;
    localparam logic [2:0] KP_CHANGE = 3'b110;
    localparam logic [2:0] KP_CANCEL = 3'b111;

    // flags = {candy_out, change_100, coin_reject, deny, busy}
    localparam logic [4:0] F_NONE   = 5'b00000;
    localparam logic [4:0] F_CANDY  = 5'b10001;
    localparam logic [4:0] F_CANREJ = 5'b10101;
    localparam logic [4:0] F_CHG    = 5'b01001;
    localparam logic [4:0] F_CHGL   = 5'b01000;
    localparam logic [4:0] F_REJ    = 5'b00100;
    localparam logic [4:0] F_DENY   = 5'b00010;
    localparam logic [4:0] F_BUSY   = 5'b00001;

    typedef struct {
        int          cyc;
        logic [10:0] cr;
        logic [4:0]  f;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  kp_code;
    logic [10:0] credit;
    logic        candy_out;
    logic        change_100;
    logic        coin_reject;
    logic        deny;
    logic        busy;

    exp_t sb[$];
    int   cyc;
    int   t0;
    int   vectors;
    int   miscompares;
    bit   mon_en;
    logic [15:0] prev_t;

    vend_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .kp_code     (kp_code),
        .credit      (credit),
        .candy_out   (candy_out),
        .change_100  (change_100),
        .coin_reject (coin_reject),
        .deny        (deny),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output tuple consumes one expected entry.
    always @(negedge clk) begin
        logic [15:0] cur;
        exp_t e;
        cur = {credit, candy_out, change_100, coin_reject, deny, busy};
        if (mon_en && (cur !== prev_t)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change cyc=%0d got credit=%0d flags=%b, required no change",
                         cyc, credit, cur[4:0]);
            end else begin
                e = sb.pop_front();
                if ((e.cyc != cyc) || (e.cr !== credit) || (e.f !== cur[4:0])) begin
                    miscompares++;
                    $display("FAIL change cyc=%0d credit=%0d flags=%b, required cyc=%0d credit=%0d flags=%b",
                             cyc, credit, cur[4:0], e.cyc, e.cr, e.f);
                end
            end
            prev_t = cur;
        end
    end

    task automatic set_kp(input logic [2:0] c);
        @(negedge clk);
        kp_code = c;
    endtask

    task automatic press(input logic [2:0] c);
        @(negedge clk);
        kp_code = c;
        t0 = cyc;
    endtask

    task automatic expect_at(input int off, input int cr, input logic [4:0] f);
        exp_t e;
        e.cyc = t0 + off;
        e.cr  = 11'(cr);
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic coin(input logic [2:0] c, input int cr, input bit rej);
        press(c);
        if (rej) begin
            expect_at(1, cr, F_REJ);
            expect_at(2, cr, F_NONE);
        end else begin
            expect_at(1, cr, F_NONE);
        end
        set_kp(KP_NONE);
    endtask

    initial begin
        cyc = 0; t0 = 0; vectors = 0; miscompares = 0; mon_en = 1'b0;
        prev_t = 16'h0000;
        kp_code = KP_NONE;
        reset = 1'b1;
        #1 reset = 1'b0;
        #3;
        vectors++;
        if ({credit, candy_out, change_100, coin_reject, deny, busy} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state got credit=%0d flags=%b, required 0",
                     credit, {candy_out, change_100, coin_reject, deny, busy});
        end
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Held coin100 gives one event, then coin500.
        press(KP_C100);
        expect_at(1, 100, F_NONE);
        repeat (19) @(negedge clk);
        set_kp(KP_NONE);
        coin(KP_C500, 600, 1'b0);

        // Candy purchase: 4 clocks of candy_out, 300 remains.
        press(KP_CANDY);
        expect_at(1, 300, F_CANDY);
        expect_at(5, 300, F_NONE);
        set_kp(KP_NONE);
        repeat (6) @(negedge clk);

        // Change of 300: pulses 4 clocks apart, busy drops with the last.
        press(KP_CHANGE);
        expect_at(1, 300, F_BUSY);
        expect_at(2, 200, F_CHG);
        expect_at(3, 200, F_BUSY);
        expect_at(6, 100, F_CHG);
        expect_at(7, 100, F_BUSY);
        expect_at(10, 0, F_CHGL);
        expect_at(11, 0, F_NONE);
        set_kp(KP_NONE);
        repeat (12) @(negedge clk);

        // Insufficient credit deny.
        coin(KP_C100, 100, 1'b0);
        press(KP_CANDY);
        expect_at(1, 100, F_DENY);
        expect_at(2, 100, F_NONE);
        set_kp(KP_NONE);

        // Ceiling: 800+500 rejected, 900+100 accepted, 1000+100 rejected.
        coin(KP_C500, 600, 1'b0);
        coin(KP_C100, 700, 1'b0);
        coin(KP_C100, 800, 1'b0);
        coin(KP_C500, 800, 1'b1);
        coin(KP_C100, 900, 1'b0);
        coin(KP_C100, 1000, 1'b0);
        coin(KP_C100, 1000, 1'b1);

        // Coin during dispense is rejected; change held across the return
        // to IDLE does not start a payout.
        press(KP_CANDY);
        expect_at(1, 700, F_CANDY);
        expect_at(3, 700, F_CANREJ);
        expect_at(4, 700, F_CANDY);
        expect_at(5, 700, F_NONE);
        set_kp(KP_NONE);
        set_kp(KP_C100);
        set_kp(KP_NONE);
        set_kp(KP_CHANGE);
        repeat (8) @(negedge clk);
        set_kp(KP_NONE);

        // Re-pressed change pays out all 700.
        press(KP_CHANGE);
        expect_at(1, 700, F_BUSY);
        for (int k = 0; k < 7; k++) begin
            expect_at(2 + 4 * k, 600 - 100 * k, (k < 6) ? F_CHG : F_CHGL);
            expect_at(3 + 4 * k, 600 - 100 * k, (k < 6) ? F_BUSY : F_NONE);
        end
        set_kp(KP_NONE);
        repeat (32) @(negedge clk);

        // 001 -> 010 with no release in between: one event only.
        press(KP_C100);
        expect_at(1, 100, F_NONE);
        set_kp(KP_C500);
        repeat (3) @(negedge clk);
        set_kp(KP_NONE);
        repeat (2) @(negedge clk);

        // Reset in the middle of a 500 payout.
        coin(KP_C100, 200, 1'b0);
        coin(KP_C100, 300, 1'b0);
        coin(KP_C100, 400, 1'b0);
        coin(KP_C100, 500, 1'b0);
        press(KP_CANCEL);
        expect_at(1, 500, F_BUSY);
        expect_at(2, 400, F_CHG);
        expect_at(3, 400, F_BUSY);
        expect_at(6, 300, F_CHG);
        expect_at(7, 300, F_BUSY);
        expect_at(8, 0, F_NONE);
        set_kp(KP_NONE);
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({credit, candy_out, change_100, coin_reject, deny, busy} !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset got credit=%0d flags=%b, required 0",
                     credit, {candy_out, change_100, coin_reject, deny, busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        coin(KP_C100, 100, 1'b0);
        coin(KP_C500, 600, 1'b0);
        repeat (5) @(negedge clk);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_change got none, required cyc=%0d credit=%0d flags=%b",
                     e.cyc, e.cr, e.f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Vending-machine transaction controller, directly downstream of the keypad mapper. Consumes the mapper's registered 3-bit key code and accumulates coin credit. Dispenses candy when credit covers the price and returns change as a train of 100-unit pulses. Drives the dispenser solenoid, the change hopper and the credit display.

Parameters:
CANDY_PRICE, 300, candy price in currency units; must be a multiple of 100 and greater than 0.
MAX_CREDIT, 1000, credit ceiling; a coin that would exceed it is rejected.
CREDIT_W, 11, credit register width; must hold MAX_CREDIT.
DISPENSE_CYCLES, 4, candy_out high time in clocks (≥1).
CHANGE_GAP, 4, clocks between change_100 pulses (≥2).

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
kp_code  input  3  key code from mapper: 000 none, 001 coin100, 010 coin500, 101 candy, 110 change, 111 cancel; 011/100 unused.
credit  output  CREDIT_W  current credit, for display.
candy_out  output  1  dispenser drive.
change_100  output  1  one-clock pulse = eject one 100-unit coin.
coin_reject  output  1  one-clock pulse = coin refused, returned by coin path.
deny  output  1  one-clock pulse = candy requested with insufficient credit.
busy  output  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset (reset=0, async): state IDLE, credit=0, all outputs 0, kp_prev=000, counters 0.
- Key event: kp_code≠000 and kp_prev==000 at a clock edge; kp_prev <= kp_code every cycle.
- A held key gives exactly one event. A direct change from one nonzero code to another gives no event.
- Codes 011/100 are never events.
- Effects of an event register on the same edge, i.e. outputs change 1 clock after kp_code is first sampled nonzero.
- States: IDLE, DISPENSE, CHANGE.
- IDLE, coin100/coin500: if credit+value ≤ MAX_CREDIT, credit += value; else credit unchanged, coin_reject=1 for 1 clock.
- IDLE, candy: if credit ≥ CANDY_PRICE, credit -= CANDY_PRICE, go to DISPENSE, load counter DISPENSE_CYCLES-1; else deny=1 for 1 clock.
- IDLE, change or cancel: if credit>0, go to CHANGE with counter=0; if credit==0, no action.
- DISPENSE: candy_out=1 every cycle in state, giving exactly DISPENSE_CYCLES clocks. Counter decrements; at 0, return to IDLE. Remaining credit is kept (repeat purchase allowed, no auto-refund).
- CHANGE: when counter==0: change_100=1 for that clock, credit -= 100, counter <= CHANGE_GAP-1. If credit was 100 (becomes 0), return to IDLE on the same edge. Otherwise counter decrements each clock. Pulses are therefore exactly CHANGE_GAP clocks apart; pulse count = credit/100 at entry.
- busy=1 throughout DISPENSE and CHANGE.
- Events while busy:
  - coin100/coin500: coin_reject pulse; credit untouched.
  - All other codes: ignored, not queued.
  - kp_prev keeps tracking, so a key held across the return to IDLE does not fire.
- credit never wraps; the ≤MAX_CREDIT check uses a CREDIT_W+1-bit sum.
- Reset mid-DISPENSE or mid-CHANGE: immediate return to reset values. Credit is lost; a partial refund is not resumed.
- Credit is always a multiple of 100.

Decomposition:
- Package vend_pkg: kp code constants (KP_NONE, KP_C100, KP_C500, KP_CANDY, KP_CHANGE, KP_CANCEL), coin values (100, 500), state encoding.
- Sub-module kp_event_det: registers kp_prev and outputs a one-clock event plus the latched code.
- vend_ctrl instantiates kp_event_det and holds the FSM, credit and counters.

Test Plan:
- Press coin100 held 20 clocks, then coin500 → credit 100 after first edge (single event despite hold), then 600; no coin_reject.
- credit=600, candy → credit 300 on event edge; candy_out high exactly 4 clocks; busy high 4 clocks; back in IDLE with 300.
- credit=300, change → change_100 pulses at clocks 1, 5, 9 after event; credit 200/100/0; busy drops with last pulse; exactly 3 pulses.
- credit=100, candy → deny pulse 1 clock, credit stays 100. credit=800, coin500 → coin_reject, credit stays 800. credit=900, coin100 → credit 1000 (boundary accepted).
- During DISPENSE: coin100 → coin_reject, credit unchanged; change key held across return to IDLE → no CHANGE entry until released and re-pressed. kp_code 001→010 without 000 between → only one event.
- credit=500, cancel, assert reset after 2nd change_100 pulse → all outputs 0 asynchronously, credit 0, state IDLE; after release, coin100 → credit 100.
